// File: rtl/fpu_arb_pkg.sv
// Shared constants for the fpu arbiter: FSM state encodings, fpu opcodes, word width.
package fpu_arb_pkg;

   localparam int FP_W = 32;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

endpackage

// File: rtl/fpu_rr_pick.sv
// Combinational winner select: round-robin after last_i, or lowest index wins
// when FPU_ARB_FIXED_PRIO_EN is defined.
module fpu_rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  last_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [IDW-1:0]  idx_o,
   output logic            any_o
);

   logic [NREQ-1:0] cand;

`ifdef FPU_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last_i;
   assign cand = req_i;
`else
   logic [NREQ-1:0] hi_mask;
   logic [NREQ-1:0] req_hi;

   always_comb begin
      hi_mask = '0;
      for (int i = 0; i < NREQ; i++) begin
         hi_mask[i] = (i > int'(last_i));
      end
   end

   // Requests above the last winner go first; otherwise wrap to the bottom.
   assign req_hi = req_i & hi_mask;
   assign cand   = (|req_hi) ? req_hi : req_i;
`endif

   always_comb begin
      idx_o = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (cand[i]) idx_o = IDW'(i);
      end
   end

   assign gnt_o = cand & (~cand + NREQ'(1));
   assign any_o = |req_i;

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one fpu among NREQ requesters with tagged responses.
// Optional macro FPU_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module fpu_arbiter
   import fpu_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int FPU_LAT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*FP_W-1:0] req_a,
   input  logic [NREQ*FP_W-1:0] req_b,
   input  logic [NREQ*2-1:0]    req_op,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [IDW-1:0]       resp_id,
   output logic [FP_W-1:0]      resp_data,
   output logic [FP_W-1:0]      fpu_a,
   output logic [FP_W-1:0]      fpu_b,
   output logic [1:0]           fpu_op,
   input  logic [FP_W-1:0]      fpu_out,
   output logic [1:0]           state_dbg
);

   localparam int CNTW = (FPU_LAT < 2) ? 1 : $clog2(FPU_LAT + 1);

   // Handshakes: a transfer happens on a posedge where valid and ready are both high;
   // requesters hold valid and operands until ready, the arbiter holds the result until resp_ready.

   logic [1:0]      state_q, state_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic [FP_W-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
   logic [1:0]      op_q, op_d;
   logic [IDW-1:0]  id_q, id_d;
   logic [IDW-1:0]  pick_last;

   logic [NREQ-1:0] pick_gnt;
   logic [IDW-1:0]  pick_idx;
   logic            pick_any;

   logic [FP_W-1:0] a_arr [NREQ];
   logic [FP_W-1:0] b_arr [NREQ];
   logic [1:0]      op_arr [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_split
      assign a_arr[g]  = req_a[FP_W*g +: FP_W];
      assign b_arr[g]  = req_b[FP_W*g +: FP_W];
      assign op_arr[g] = req_op[2*g +: 2];
   end

`ifdef FPU_ARB_FIXED_PRIO_EN
   assign pick_last = '0;
`else
   logic [IDW-1:0] last_q, last_d;
   assign pick_last = last_q;
`endif

   fpu_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_i  (req_valid),
      .last_i (pick_last),
      .gnt_o  (pick_gnt),
      .idx_o  (pick_idx),
      .any_o  (pick_any)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      id_d    = id_q;
      data_d  = data_q;
`ifndef FPU_ARB_FIXED_PRIO_EN
      last_d  = last_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               a_d     = a_arr[pick_idx];
               b_d     = b_arr[pick_idx];
               op_d    = op_arr[pick_idx];
               id_d    = pick_idx;
`ifndef FPU_ARB_FIXED_PRIO_EN
               last_d  = pick_idx;
`endif
               cnt_d   = CNTW'(FPU_LAT);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Operands were stable one edge before the count starts, so cnt==0 marks a fresh fpu_out.
            if (cnt_q == '0) begin
               data_d  = fpu_out;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNTW'(1);
            end
         end
         ST_RESP: begin
            if (resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= OP_ADD;
         id_q    <= '0;
         data_q  <= '0;
`ifndef FPU_ARB_FIXED_PRIO_EN
         last_q  <= IDW'(NREQ - 1);
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         id_q    <= id_d;
         data_q  <= data_d;
`ifndef FPU_ARB_FIXED_PRIO_EN
         last_q  <= last_d;
`endif
      end
   end

   assign req_ready  = (state_q == ST_IDLE) ? pick_gnt : '0;
   assign resp_valid = (state_q == ST_RESP);
   assign resp_id    = id_q;
   assign resp_data  = data_q;
   assign fpu_a      = a_q;
   assign fpu_b      = b_q;
   assign fpu_op     = op_q;
   assign state_dbg  = state_q;

endmodule
